// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - CPU-written 8-entry FIFO draining into an LSB-first async serial transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [7:0]        wd,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              ovf,
    output logic              txd
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              ovf_q;

    state_t            state;
    state_t            state_d;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bitcnt;
    logic [2:0]        bitcnt_d;
    logic [7:0]        shift;
    logic [7:0]        shift_d;
    logic              par_q;
    logic              par_d;
    logic              txd_q;
    logic              txd_d;

    logic              push;
    logic              pop;
    logic              baud_end;
    logic [7:0]        head;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign busy     = (state != S_IDLE);
    assign txd      = txd_q;

    // full is the pre-edge value, so a pop on this edge never makes room for the write
    assign push     = we && !full;
    assign pop      = (state == S_IDLE) && !empty;
    assign baud_end = (baud == BAUD_LAST);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (we && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // State register; txd is registered so the line never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
            par_q  <= 1'b0;
            txd_q  <= 1'b1;
        end else begin
            state  <= state_d;
            baud   <= baud_d;
            bitcnt <= bitcnt_d;
            shift  <= shift_d;
            par_q  <= par_d;
            txd_q  <= txd_d;
        end
    end

    always_comb begin
        state_d  = state;
        baud_d   = baud;
        bitcnt_d = bitcnt;
        shift_d  = shift;
        par_d    = par_q;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_d  = S_START;
                    shift_d  = head;
                    par_d    = ^head;
                    baud_d   = '0;
                    bitcnt_d = '0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt + 3'd1;
                    end
                end else begin
                    baud_d = baud + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is derived from the upcoming state so txd changes on the same edge as the state
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - scoreboard bench for uart_tx_port: queued expected bytes checked bit-exactly by a txd monitor
module tb_uart_tx_port;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [7:0] wd;
    logic       full, empty, busy, ovf, txd;
    logic [3:0] count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    bit         mon_busy = 1'b0;

    uart_tx_port #(.CLKS_PER_BIT(CPB), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wd    (wd),
        .full  (full),
        .empty (empty),
        .count (count),
        .busy  (busy),
        .ovf   (ovf),
        .txd   (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; returns just after the sampling edge
    task automatic wr(input logic [7:0] d, input bit accepted);
        we = 1'b1;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic wait_busy(input logic want, input int budget, input string name);
        int n = 0;
        while (busy !== want && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(busy === want), 32'd1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy !== 1'b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    // Monitor: each frame is compared cycle by cycle against the byte at the head of the scoreboard
    initial begin : monitor
        logic [10:0] fr;
        logic [7:0]  b;
        int          bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame actual=start_bit required=idle_line");
                    b = 8'h00;
                end else begin
                    b = exp_q.pop_front();
                end
`ifdef UART_TX_PARITY_EN
                fr = {1'b1, ^b, b, 1'b0};
`else
                fr = {1'b1, 1'b1, b, 1'b0};
`endif
                bad = 0;
                aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd !== fr[k / CPB] || busy !== 1'b1) bad++;
                end
                if (!aborted) check($sformatf("frame_%02h_bad_cycles", b), bad, 0);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wd    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single byte 0x55: popped one edge after the write
        wr(8'h55, 1'b1);
        check("single_count_after_write", count, 1);
        @(posedge clk);
        #1;
        check("single_count_after_pop", count, 0);
        check("single_busy_after_pop", busy, 1);
        check("single_txd_start", txd, 0);
        wait_drain(FRAME + 20, "single_drain");
        check("single_busy_end", busy, 0);
        check("single_txd_end", txd, 1);

        // Burst of 9 from idle, then a 10th write into a full FIFO
        starts.delete();
        for (int i = 0; i < 9; i++) wr(8'(i), 1'b1);
        check("burst_count", count, 8);
        check("burst_full", full, 1);
        check("burst_empty", empty, 0);
        check("burst_ovf_before", ovf, 0);
        wr(8'hFF, 1'b0);
        check("burst_ovf_after", ovf, 1);
        check("burst_count_after_ovf", count, 8);
        wait_drain(10 * (FRAME + 1) + 20, "burst_drain");
        check("burst_frames", starts.size(), 9);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("burst_spacing_%0d", i), starts[i] - starts[i-1], FRAME + 1);
        check("burst_empty_end", empty, 1);
        check("burst_busy_end", busy, 0);
        check("burst_ovf_sticky", ovf, 1);

        // Write on the same edge as a pop with three bytes queued
        wr(8'h10, 1'b1);
        wait_busy(1'b1, 10, "same_edge_first_busy");
        wr(8'h21, 1'b1);
        wr(8'h32, 1'b1);
        wr(8'h43, 1'b1);
        check("same_edge_count_pre", count, 3);
        wait_busy(1'b0, FRAME + 10, "same_edge_idle");
        check("same_edge_count_idle", count, 3);
        we = 1'b1;
        wd = 8'h54;
        @(posedge clk);
        #1;
        we = 1'b0;
        exp_q.push_back(8'h54);
        check("same_edge_count_post", count, 3);
        check("same_edge_busy_post", busy, 1);
        wait_drain(5 * (FRAME + 1) + 20, "same_edge_drain");

        // Reset during data bit 3 of 0xA5 with two bytes still queued
        wr(8'hA5, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        check("rst_mid_count_pre", count, 2);
        repeat (16) @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_txd", txd, 1);
        check("rst_mid_count", count, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovf", ovf, 0);
        check("rst_mid_empty", empty, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_txd", txd, 1);
        check("post_rst_count", count, 0);

        // 0x07 exercises the parity bit when it is compiled in
        wr(8'h07, 1'b1);
        wait_drain(FRAME + 20, "byte07_drain");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial output port for the 8-bit CPU. The CPU datapath is the writer: it deposits bytes with a single-cycle write strobe, in the same style as the data-memory write port. This block is the reader: it drains an internal 8-entry FIFO and shifts each byte out on a single asynchronous serial line (8N1, LSB first). FIFO status flags let CPU code poll before writing.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per serial bit. Legal range 2..65535.
- ADDR_W, default 3: FIFO address width. Depth = 2**ADDR_W = 8.

Ports:
- clk, input, 1: clock. All state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- we, input, 1: CPU write strobe. Sampled on the rising edge of clk.
- wd, input, 8: byte to enqueue when we=1.
- full, output, 1: FIFO holds 2**ADDR_W entries.
- empty, output, 1: FIFO holds 0 entries.
- count, output, ADDR_W+1: FIFO occupancy.
- busy, output, 1: serializer is not in IDLE.
- ovf, output, 1: sticky overflow. Set when we=1 while full=1. Cleared only by reset.
- txd, output, 1: serial line. Idle level is 1. Driven from a register.

## Operation
- Reset values:
  - txd=1, busy=0, full=0, empty=1, count=0, ovf=0.
  - FSM in IDLE; read and write pointers at 0.
- Write path:
  - A write with we=1 and full=0 stores wd at the write pointer and advances the pointer, which wraps modulo depth.
  - A write with we=1 and full=1 drops the byte, leaves the FIFO unchanged, and sets ovf.
  - full is evaluated before the edge. A pop on the same edge does not make room for the write.
- Read path (FSM states):
  - IDLE: txd=1. If empty=0, pop the head into the shift register, load the bit counter to 0 and the baud counter to 0, then go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to PARITY if compiled in, else STOP.
  - PARITY (optional): one bit time, txd = even parity (XOR of the 8 data bits).
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Write and pop on the same edge: count is unchanged, and both pointers advance.
- There is no bypass path. A byte written into an empty FIFO is popped on the following edge.
- Baud counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, and the bit advances at terminal count.

## Timing
- A write sampled at edge E0 into an idle, empty port:
  - count=1 after E0.
  - At E1, the byte is popped; count=0, busy=1, and txd falls to 0.
- Frame length:
  - 10*CLKS_PER_BIT cycles from the txd fall to the end of the stop bit.
  - 11*CLKS_PER_BIT with parity.
- Back-to-back frames: STOP returns to IDLE, so there is exactly one IDLE cycle (txd=1) between consecutive frames. Start-to-start spacing is 10*CLKS_PER_BIT+1.
- count, full and empty are registered and reflect the state after each edge.
- Reset asserted mid-frame:
  - txd goes to 1 immediately, without waiting for clk.
  - The FIFO is flushed, the frame is abandoned, and ovf is cleared.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in and every frame carries an even parity bit between data bit 7 and the stop bit.
- UART_TX_PARITY_EN undefined: no PARITY state; frames are plain 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=4 and parity disabled unless stated.
- Single byte 0x55:
  - txd reads 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles.
  - busy=1 for 40 cycles, then 0.
- Burst of 9 back-to-back writes 0x00..0x08 from idle:
  - Byte 0x00 is popped at the first following edge, so full=1 and count=8 after the 9th write.
  - A 10th write of 0xFF sets ovf=1, and 0xFF never appears on txd.
- Drain after the burst:
  - Bytes appear in order 0x00..0x08.
  - Start edges are 41 cycles apart.
  - empty=1 once the last frame is popped; busy=0 after its stop bit.
- Write on the same edge a pop occurs (FIFO count=3, serializer in IDLE):
  - count stays 3.
  - The written byte is transmitted after the existing three.
- Reset during DATA bit 3 of 0xA5 with 2 bytes queued:
  - txd=1 and count=0 within the reset assertion, with no clk edge needed.
  - After release, no frame starts until a new write.
- UART_TX_PARITY_EN defined, byte 0x07:
  - Parity bit is 1.
  - Frame is 0,1,1,1,0,0,0,0,0,1,1; 44 cycles total.
